// File: rtl/hzd_pkg.sv
// Shared decode constants and instruction classes for the D-stage hazard unit.
package hzd_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_LUI    = 6'h0f;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  localparam logic [1:0] TUSE_0 = 2'd0;
  localparam logic [1:0] TUSE_1 = 2'd1;
  localparam logic [1:0] TUSE_2 = 2'd2;

  typedef enum logic [2:0] {CL_R, CL_IMM, CL_LD, CL_ST, CL_BR, CL_J, CL_MD} instr_class_e;

  function automatic instr_class_e classify(logic [5:0] op, logic [5:0] fn);
    instr_class_e cls;
    cls = CL_J;  // unrecognised opcodes read no GPRs
    if (op == OP_RTYPE) begin
      case (fn)
        FN_JR, FN_JALR: cls = CL_J;
        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: cls = CL_MD;
        default: cls = CL_R;
      endcase
    end else if (op == OP_REGIMM || op == OP_BEQ || op == OP_BNE ||
                 op == OP_BLEZ || op == OP_BGTZ) begin
      cls = CL_BR;
    end else if (op == OP_J || op == OP_JAL) begin
      cls = CL_J;
    end else if (op[5:3] == 3'b001) begin
      cls = CL_IMM;
    end else if (op[5:3] == 3'b100) begin
      cls = CL_LD;
    end else if (op[5:3] == 3'b101) begin
      cls = CL_ST;
    end
    return cls;
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Down-counter tracking how long the multiply/divide unit stays occupied.
module md_busy_tracker #(
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic e_md_start,
  input  logic e_md_div,
  output logic md_busy
);

  localparam int unsigned CW = $clog2(DIV_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (e_md_start) begin
      cnt_d = e_md_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign md_busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit.sv
// D-stage stall/forward controller with per-operand tUse and MDU occupancy tracking.
// Optional perf counters are built when HZD_PERF_CNT_EN is defined.
module hazard_unit
  import hzd_pkg::*;
#(
  parameter int unsigned NSTG    = 2,
  parameter int unsigned TW      = 2,
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [5:0]                   d_opcode,
  input  logic [5:0]                   d_funct,
  input  logic [4:0]                   d_rs,
  input  logic [4:0]                   d_rt,
  input  logic [NSTG-1:0]              s_wen,
  input  logic [5*NSTG-1:0]            s_wreg,
  input  logic [TW*NSTG-1:0]           s_tnew,
  input  logic                         e_md_start,
  input  logic                         e_md_div,
  output logic                         stall,
  output logic [$clog2(NSTG+1)-1:0]    fwd_rs,
  output logic [$clog2(NSTG+1)-1:0]    fwd_rt,
  output logic                         md_busy
`ifdef HZD_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_stall_cyc,
  output logic [31:0]                  perf_md_stall_cyc
`endif
);

  localparam int unsigned FW = $clog2(NSTG + 1);

  instr_class_e cls;
  logic         rs_used, rt_used, md_class, sa_shift;
  logic [1:0]   rs_tuse, rt_tuse;

  always_comb begin
    cls      = classify(d_opcode, d_funct);
    sa_shift = (d_funct == FN_SLL) || (d_funct == FN_SRL) || (d_funct == FN_SRA);
    md_class = (cls == CL_MD);
    rs_used  = 1'b0;
    rs_tuse  = TUSE_0;
    rt_used  = 1'b0;
    rt_tuse  = TUSE_0;
    unique case (cls)
      CL_R: begin
        rt_used = 1'b1;
        rt_tuse = TUSE_1;
        rs_used = !sa_shift;
        rs_tuse = TUSE_1;
      end
      CL_IMM: begin
        rs_used = (d_opcode != OP_LUI);
        rs_tuse = TUSE_1;
      end
      CL_LD: begin
        rs_used = 1'b1;
        rs_tuse = TUSE_1;
      end
      CL_ST: begin
        rs_used = 1'b1;
        rs_tuse = TUSE_1;
        rt_used = 1'b1;
        rt_tuse = TUSE_2;
      end
      CL_BR: begin
        rs_used = 1'b1;
        rs_tuse = TUSE_0;
        rt_used = (d_opcode == OP_BEQ) || (d_opcode == OP_BNE);
        rt_tuse = TUSE_0;
      end
      CL_J: begin
        rs_used = (d_opcode == OP_RTYPE);
        rs_tuse = TUSE_0;
      end
      CL_MD: begin
        rs_used = (d_funct != FN_MFHI) && (d_funct != FN_MFLO);
        rs_tuse = TUSE_1;
        rt_used = d_funct[3];
        rt_tuse = TUSE_1;
      end
      default: ;
    endcase
  end

  logic [NSTG-1:0] rs_match, rt_match;

  for (genvar g = 0; g < NSTG; g++) begin : g_match
    logic [4:0] wreg;
    assign wreg        = s_wreg[5*g +: 5];
    assign rs_match[g] = s_wen[g] && (wreg != 5'd0) && (wreg == d_rs);
    assign rt_match[g] = s_wen[g] && (wreg != 5'd0) && (wreg == d_rt);
  end

  logic          rs_hit, rt_hit;
  logic [FW-1:0] rs_idx, rt_idx;
  logic [TW-1:0] rs_tnew, rt_tnew;

  // Walk oldest to nearest so the lowest-index match shadows older ones.
  always_comb begin
    rs_hit  = 1'b0;
    rs_idx  = '0;
    rs_tnew = '0;
    rt_hit  = 1'b0;
    rt_idx  = '0;
    rt_tnew = '0;
    for (int i = int'(NSTG) - 1; i >= 0; i--) begin
      if (rs_match[i]) begin
        rs_hit  = 1'b1;
        rs_idx  = FW'(i + 1);
        rs_tnew = s_tnew[TW*i +: TW];
      end
      if (rt_match[i]) begin
        rt_hit  = 1'b1;
        rt_idx  = FW'(i + 1);
        rt_tnew = s_tnew[TW*i +: TW];
      end
    end
  end

  logic haz_rs, haz_rt, md_term;

  assign haz_rs  = rs_used && rs_hit && (32'(rs_tnew) > 32'(rs_tuse));
  assign haz_rt  = rt_used && rt_hit && (32'(rt_tnew) > 32'(rt_tuse));
  assign md_term = md_class && (md_busy || e_md_start);
  assign stall   = haz_rs || haz_rt || md_term;
  assign fwd_rs  = (rs_used && rs_hit && (rs_tnew == '0)) ? rs_idx : '0;
  assign fwd_rt  = (rt_used && rt_hit && (rt_tnew == '0)) ? rt_idx : '0;

  md_busy_tracker #(
    .MUL_CYC (MUL_CYC),
    .DIV_CYC (DIV_CYC)
  ) u_md_busy_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .e_md_start (e_md_start),
    .e_md_div   (e_md_div),
    .md_busy    (md_busy)
  );

`ifdef HZD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_md_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_md_q    <= '0;
    end else begin
      if (stall) perf_stall_q <= perf_stall_q + 32'd1;
      if (md_term && !haz_rs && !haz_rt) perf_md_q <= perf_md_q + 32'd1;
    end
  end

  assign perf_stall_cyc    = perf_stall_q;
  assign perf_md_stall_cyc = perf_md_q;
`endif

endmodule
